// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// All row and column vectors are active-low.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      WAIT_REL = 2'd3
   } state_t;

   localparam logic [3:0] COL_INIT = 4'b1110;
   localparam logic [3:0] ROW_IDLE = 4'b1111;

   typedef struct packed {
      logic       valid;
      logic [1:0] idx;
   } onehot_t;

   // valid only when exactly one bit is low; idx is the position of that bit
   function automatic onehot_t onehot0_index(input logic [3:0] v);
      onehot_t r;
      r.valid = 1'b0;
      r.idx   = 2'd0;
      case (v)
         4'b1110: begin r.valid = 1'b1; r.idx = 2'd0; end
         4'b1101: begin r.valid = 1'b1; r.idx = 2'd1; end
         4'b1011: begin r.valid = 1'b1; r.idx = 2'd2; end
         4'b0111: begin r.valid = 1'b1; r.idx = 2'd3; end
         default: begin r.valid = 1'b0; r.idx = 2'd0; end
      endcase
      return r;
   endfunction

   function automatic logic [3:0] col_rotl(input logic [3:0] c);
      return {c[2:0], c[3]};
   endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running divider: tick is high for one clk every SCAN_DIV cycles.
// Also usable as the display driver's refresh strobe.
module keypad_tick_gen #(
   parameter int SCAN_DIV = 100000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam logic [31:0] DIV_LAST = 32'(SCAN_DIV - 1);

   logic [31:0] cnt;

   assign tick = (cnt == DIV_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + 32'd1;
   end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 hex keypad scanner: column drive, row debounce, key strobe and a
// nibble-shifting entry register.
//
// state    | meaning
// ---------+------------------------------------------------------------
// SCAN     | rotate the low column each tick until one row reads low
// DEBOUNCE | same row pattern must persist for DEB_CNT ticks
// PRESSED  | single clk: key_valid high, code and entry register updated
// WAIT_REL | column held until rows read idle for DEB_CNT-1 ticks
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int size     = 8,
   parameter int SCAN_DIV = 100000,
   parameter int DEB_CNT  = 20
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [3:0]      row_in,
   output logic [3:0]      col_out,
   output logic            key_valid,
   output logic [3:0]      key_code,
   output logic [size-1:0] data
);

   localparam int               DEB_W    = $clog2(DEB_CNT) + 1;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);

   logic             tick;
   logic [3:0]       row_s1, rs;
   state_t           state, state_nxt;
   logic [DEB_W-1:0] deb, deb_nxt;
   logic [3:0]       col_nxt;
   logic [3:0]       row_lat, row_lat_nxt;
   logic [1:0]       row_idx, row_idx_nxt;
   logic             accept;
   onehot_t          rs_dec, col_dec;
   logic [3:0]       code_nxt;
   logic [size-1:0]  data_shift;

   keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // row_in comes straight from the keypad pins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_s1 <= ROW_IDLE;
         rs     <= ROW_IDLE;
      end else begin
         row_s1 <= row_in;
         rs     <= row_s1;
      end
   end

   assign rs_dec   = onehot0_index(rs);
   assign col_dec  = onehot0_index(col_out);
   assign code_nxt = {row_idx, col_dec.idx};

   generate
      if (size > 4) begin : g_shift
         assign data_shift = {data[size-5:0], code_nxt};
      end else begin : g_nibble
         assign data_shift = code_nxt;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= SCAN;
         deb     <= '0;
         col_out <= COL_INIT;
         row_lat <= ROW_IDLE;
         row_idx <= 2'd0;
      end else begin
         state   <= state_nxt;
         deb     <= deb_nxt;
         col_out <= col_nxt;
         row_lat <= row_lat_nxt;
         row_idx <= row_idx_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      deb_nxt     = deb;
      col_nxt     = col_out;
      row_lat_nxt = row_lat;
      row_idx_nxt = row_idx;
      accept      = 1'b0;

      case (state)
         SCAN: begin
            if (tick) begin
               if (rs_dec.valid) begin
                  row_lat_nxt = rs;
                  row_idx_nxt = rs_dec.idx;
                  deb_nxt     = '0;
                  state_nxt   = DEBOUNCE;
               end else begin
                  // idle or ghosting: move on; a corrupted column restarts at COL_INIT
                  col_nxt = col_dec.valid ? col_rotl(col_out) : COL_INIT;
               end
            end
         end

         DEBOUNCE: begin
            if (tick) begin
               if (rs == row_lat) begin
                  deb_nxt = deb + 1'b1;
                  if (deb_nxt >= DEB_LAST) begin
                     state_nxt = PRESSED;
                     accept    = 1'b1;
                  end
               end else begin
                  state_nxt = SCAN;
                  col_nxt   = col_rotl(col_out);
               end
            end
         end

         PRESSED: begin
            deb_nxt   = '0;
            state_nxt = WAIT_REL;
         end

         WAIT_REL: begin
            if (tick) begin
               if (rs == ROW_IDLE) begin
                  deb_nxt = deb + 1'b1;
                  if (deb_nxt >= DEB_LAST) begin
                     deb_nxt   = '0;
                     state_nxt = SCAN;
                     col_nxt   = col_rotl(col_out);
                  end
               end else begin
                  deb_nxt = '0;
               end
            end
         end

         default: begin
            state_nxt = SCAN;
            col_nxt   = COL_INIT;
            deb_nxt   = '0;
         end
      endcase
   end

   // outputs load on entry to PRESSED so code and data line up with key_valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_valid <= 1'b0;
         key_code  <= 4'd0;
         data      <= '0;
      end else begin
         key_valid <= accept;
         if (accept) begin
            key_code <= code_nxt;
            data     <= data_shift;
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: a keypad model answers the column drive,
// expected strobes are queued by the stimulus and popped by a monitor.
module tb_keypad_scan;

   localparam int SIZE     = 8;
   localparam int SCAN_DIV = 4;
   localparam int DEB_CNT  = 3;

   typedef struct {
      logic [3:0]      code;
      logic [SIZE-1:0] data;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [3:0]      row_in;
   logic [3:0]      col_out;
   logic            key_valid;
   logic [3:0]      key_code;
   logic [SIZE-1:0] data;

   logic            key_down = 1'b0;
   logic [1:0]      key_row = 2'd0;
   logic [1:0]      key_col = 2'd0;
   logic            force_en = 1'b0;
   logic [3:0]      force_val = 4'hF;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   keypad_scan #(.size(SIZE), .SCAN_DIV(SCAN_DIV), .DEB_CNT(DEB_CNT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .row_in    (row_in),
      .col_out   (col_out),
      .key_valid (key_valid),
      .key_code  (key_code),
      .data      (data)
   );

   always #5 clk = ~clk;

   always_comb begin
      row_in = 4'hF;
      if (force_en)
         row_in = force_val;
      else if (key_down && !col_out[key_col])
         row_in = ~(4'b0001 << key_row);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic wait_drain(input int limit);
      int n = 0;
      while (sb_q.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("strobe_arrived", sb_q.size(), 0);
   endtask

   task automatic wait_col_change(output int n);
      logic [3:0] c0;
      c0 = col_out;
      n  = 0;
      while (col_out == c0 && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic count_col_changes(input int cycles, output int changes);
      logic [3:0] prev;
      prev    = col_out;
      changes = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (col_out != prev) changes++;
         prev = col_out;
      end
   endtask

   task automatic press(input logic [1:0] r, input logic [1:0] c,
                        input logic [3:0] code, input logic [SIZE-1:0] d,
                        input bit release_key);
      exp_t e;
      e.code = code;
      e.data = d;
      sb_q.push_back(e);
      key_row  = r;
      key_col  = c;
      key_down = 1'b1;
      wait_drain(300);
      if (release_key) begin
         repeat (40) @(negedge clk);
         key_down = 1'b0;
         repeat (16) @(negedge clk);
      end
   endtask

   initial begin
      logic [3:0] col_seq [4];
      int         n;
      exp_t       e;

      col_seq[0] = 4'b1110;
      col_seq[1] = 4'b1101;
      col_seq[2] = 4'b1011;
      col_seq[3] = 4'b0111;

      fork
         begin : monitor
            logic prev_valid = 1'b0;
            forever begin
               @(negedge clk);
               if (rst_n && key_valid) begin
                  check("no_back_to_back", prev_valid, 0);
                  if (sb_q.size() == 0) begin
                     check("unexpected_strobe", {28'd0, key_code}, 32'hFFFF_FFFF);
                  end else begin
                     e = sb_q.pop_front();
                     check("key_code", key_code, e.code);
                     check("data", data, e.data);
                  end
               end
               prev_valid = rst_n && key_valid;
            end
         end
         begin : watchdog
            #200000;
            $display("FAIL watchdog: actual timeout required finish");
            $fatal(1, "watchdog expired");
         end
      join_none

      // reset values
      repeat (3) @(negedge clk);
      check("rst_col_out", col_out, 4'b1110);
      check("rst_key_valid", key_valid, 0);
      check("rst_key_code", key_code, 0);
      check("rst_data", data, 0);
      rst_n = 1'b1;

      // idle rotation, one step per SCAN_DIV clocks
      for (int i = 1; i <= 16; i++) begin
         wait_col_change(n);
         check("col_interval", n, SCAN_DIV);
         check("col_seq", col_out, col_seq[i % 4]);
      end
      check("idle_data", data, 0);

      // single key, then sequence showing the shift and oldest-nibble drop
      press(2'd1, 2'd2, 4'h6, 8'h06, 1'b1);
      press(2'd3, 2'd3, 4'hF, 8'h6F, 1'b1);
      press(2'd0, 2'd0, 4'h0, 8'hF0, 1'b1);

      // bounce: alternating pattern never survives debounce
      force_en  = 1'b1;
      force_val = 4'b1101;
      repeat (SCAN_DIV) @(negedge clk);
      force_val = 4'b1111;
      repeat (SCAN_DIV) @(negedge clk);
      force_val = 4'b1101;
      repeat (SCAN_DIV) @(negedge clk);
      force_val = 4'b1111;
      repeat (12) @(negedge clk);
      count_col_changes(20, n);
      check("bounce_rotates", n, 5);

      // two rows low: ghosting, keep rotating
      force_val = 4'b1100;
      count_col_changes(40, n);
      check("multi_rotates", n, 10);
      force_val = 4'b1111;
      force_en  = 1'b0;
      repeat (12) @(negedge clk);
      check("data_kept", data, 8'hF0);

      // reset while the key is held in WAIT_REL, then re-debounce
      press(2'd1, 2'd2, 4'h6, 8'h06, 1'b0);
      repeat (8) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_data", data, 0);
      check("async_rst_code", key_code, 0);
      check("async_rst_col", col_out, 4'b1110);
      check("async_rst_valid", key_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      press(2'd1, 2'd2, 4'h6, 8'h06, 1'b1);
      check("queue_empty", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
